control_unit_fsm: RTL and testbench
===================================

CONTROL_UNIT_FSM -- requirements
Module: control_unit_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max cycles waiting for mem_ack before error.
REQ-002 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-003 SHALL have clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have instr_valid input 1, opcode input 3, funct input 2: instruction offer.
REQ-006 SHALL have instr_ready output 1: instruction accepted when instr_valid and instr_ready are both high.
REQ-007 SHALL have mem_req output 1 and mem_ack input 1: data-memory handshake.
REQ-008 SHALL have outputs branch 2, ext_sel 2, rb_sel 1, opb_sel 1, alu_func 1, wd_sel 1: datapath controls.
REQ-009 SHALL have outputs wr_en 1, wm_en 1, flag_en 1, pc_en 1: single-cycle strobes.
REQ-010 SHALL have outputs busy 1 (state != FETCH) and err 1 (sticky fault).
REQ-011 SHALL have output retired, CNT_W bits, present only under CU_RETIRE_CNT_EN.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, ERR, one-hot or binary.
REQ-013 SHALL drive instr_ready=1 only in FETCH; on handshake it latches opcode/funct and goes to DECODE.
REQ-014 SHALL, in DECODE, register the control word and hold it stable until return to FETCH.
REQ-015 SHALL decode as follows (branch, ext_sel, opb_sel, alu_func, wd_sel, rb_sel):
 - 000/00 ADD: 11,11,0,0,0,0 write; 000/01 ADDI: 11,00,1,0,0,0 write.
 - 000/10 SUB: 11,11,0,1,0,0 write; 000/11 SUBI: 11,00,1,1,0,0 write.
 - 001/10 CMP: 11,11,0,1,0,0; 001/11 CMPI: 11,00,1,1,0,0; no write.
 - 010 LDR: 11,01,1,0,1,0 write; 011 STR: 11,01,1,0,0,1 memory write.
 - 100 JEQ: 00,10; 101 JNE: 01,10; 110 JMP: 10,10; 111 NOP: 11,10; other fields 0.
REQ-016 SHALL treat 001/00 and 001/01 as illegal: DECODE goes to ERR.
REQ-017 SHALL in EXEC: ADD/ADDI/SUB/SUBI go WB; CMP/CMPI pulse flag_en, go FETCH; LDR/STR go MEM; JEQ/JNE/JMP/NOP go FETCH.
REQ-018 SHALL in MEM hold mem_req=1; wm_en=1 with mem_req only for STR; wm_en=0 in every other state.
REQ-019 SHALL on mem_ack in MEM: LDR goes WB, STR goes FETCH; mem_req drops the next cycle.
REQ-020 SHALL count MEM cycles; reaching TIMEOUT cycles without mem_ack goes to ERR.
REQ-021 SHALL pulse wr_en for exactly one cycle, only in WB.
REQ-022 SHALL pulse pc_en for exactly one cycle on the transition into FETCH from EXEC, MEM or WB.
REQ-023 SHALL treat ERR as terminal: err=1, instr_ready=0, all strobes 0; exit only via rst.
REQ-024 SHALL give latencies from accept to pc_en of: ALU 4 cycles; CMP/branch/NOP 3; STR 3+k; LDR 4+k; k = MEM wait cycles (k>=1).

Reset
REQ-025 SHALL set on rst: state FETCH, branch=11, all other outputs and counters 0, err=0.
REQ-026 SHALL give rst priority over all events, including mid-MEM (mem_req drops next cycle) and in ERR.

Configuration
REQ-027 SHALL, with CU_RETIRE_CNT_EN defined, increment retired on each pc_en, wrapping modulo 2^CNT_W; rst clears it.
REQ-028 SHALL, without CU_RETIRE_CNT_EN, omit the retired port and its counter entirely.

Verification
REQ-029 SHALL check: ADD (000/00) accepted -> wr_en pulses in cycle 3 after accept, with ext_sel=11, opb_sel=0, alu_func=0; pc_en follows in cycle 4.
REQ-030 SHALL check: STR (011), mem_ack after 2 MEM cycles -> mem_req and wm_en high 2 cycles, rb_sel=1, wr_en never asserted.
REQ-031 SHALL check: LDR with mem_ack never asserted, TIMEOUT=4 -> ERR after 4 MEM cycles, err=1, instr_ready=0 held.
REQ-032 SHALL check: opcode 001/01 -> ERR from DECODE, no strobes asserted.
REQ-033 SHALL check: rst asserted during MEM of LDR -> next cycle FETCH, branch=11, mem_req=0, err=0.
REQ-034 SHALL check: with CU_RETIRE_CNT_EN and CNT_W=2, 5 NOPs -> retired=1 (wrap).

Source files
------------

// File: rtl/control_unit_fsm.sv
// control_unit_fsm: multi-cycle instruction control FSM; define CU_RETIRE_CNT_EN to add the retired-instruction counter port
module control_unit_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [2:0] opcode,
    input  logic [1:0] funct,
    output logic       instr_ready,
    output logic       mem_req,
    input  logic       mem_ack,
    output logic [1:0] branch,
    output logic [1:0] ext_sel,
    output logic       rb_sel,
    output logic       opb_sel,
    output logic       alu_func,
    output logic       wd_sel,
    output logic       wr_en,
    output logic       wm_en,
    output logic       flag_en,
    output logic       pc_en,
    output logic       busy,
    output logic       err
`ifdef CU_RETIRE_CNT_EN
    ,output logic [CNT_W-1:0] retired
`endif
);
    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, ERR = 3'd5;
    localparam int TW = $clog2(TIMEOUT + 1);

    if (CNT_W < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("control_unit_fsm: CNT_W and TIMEOUT must be at least 1");
    end

    logic [2:0]    state_q, state_d, op_q, op_d;
    logic [1:0]    fn_q, fn_d;
    logic [7:0]    ctrl_q, ctrl_d, dec_ctrl;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pc_en_q, pc_en_d, is_ldr, is_str, is_mem, illegal;

    assign is_ldr  = op_q == 3'b010;
    assign is_str  = op_q == 3'b011;
    assign is_mem  = is_ldr || is_str;
    assign illegal = op_q == 3'b001 && !fn_q[1];
    // control word packed as {branch, ext_sel, opb_sel, alu_func, wd_sel, rb_sel}
    assign dec_ctrl = op_q[2] ? {op_q[1:0], 6'b10_0000}
                    : op_q[1] ? {4'b11_01, 1'b1, 1'b0, is_ldr, is_str}
                    : {2'b11, fn_q[0] ? 2'b00 : 2'b11, fn_q[0], fn_q[1], 2'b00};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fn_d    = fn_q;
        ctrl_d  = ctrl_q;
        tmo_d   = '0;
        case (state_q)
            FETCH: if (instr_valid) begin
                op_d    = opcode;
                fn_d    = funct;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = illegal ? ERR : EXEC;
                ctrl_d  = dec_ctrl;
            end
            EXEC: state_d = op_q == 3'b000 ? WB : is_mem ? MEM : FETCH;
            MEM: begin
                state_d = mem_ack ? (is_ldr ? WB : FETCH) : tmo_q == TW'(TIMEOUT - 1) ? ERR : MEM;
                tmo_d   = tmo_q + TW'(1);
            end
            WB: state_d = FETCH;
            default: state_d = ERR;
        endcase
        pc_en_d = state_d == FETCH && (state_q == EXEC || state_q == MEM || state_q == WB);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            ctrl_q  <= 8'b11_00_0000;
            tmo_q   <= '0;
            pc_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            ctrl_q  <= ctrl_d;
            tmo_q   <= tmo_d;
            pc_en_q <= pc_en_d;
        end
    end

    assign {branch, ext_sel, opb_sel, alu_func, wd_sel, rb_sel} = ctrl_q;
    assign instr_ready = state_q == FETCH;
    assign busy        = !instr_ready;
    assign err         = state_q == ERR;
    assign mem_req     = state_q == MEM;
    assign wm_en       = mem_req && is_str;
    assign wr_en       = state_q == WB;
    assign flag_en     = state_q == EXEC && op_q == 3'b001;
    assign pc_en       = pc_en_q;

`ifdef CU_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb retired_d = retired_q + CNT_W'(pc_en_q);

    always_ff @(posedge clk) begin
        if (rst) retired_q <= '0;
        else retired_q <= retired_d;
    end

    assign retired = retired_q;
`endif
endmodule

// File: tb/tb_control_unit_fsm.sv
// tb_control_unit_fsm: directed and randomized checks of control_unit_fsm against a cycle-table model
module tb_control_unit_fsm;
    logic       clk = 1'b0;
    logic       rst, instr_valid, mem_ack;
    logic [2:0] opcode;
    logic [1:0] funct;
    logic       instr_ready, mem_req, rb_sel, opb_sel, alu_func, wd_sel;
    logic       wr_en, wm_en, flag_en, pc_en, busy, err;
    logic [1:0] branch, ext_sel;
    logic [7:0] st, ctrl;
    int         tests_run = 0;
    int         fails = 0;
`ifdef CU_RETIRE_CNT_EN
    logic [1:0] retired;
`endif

    always #5 clk = ~clk;

    control_unit_fsm #(.TIMEOUT(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
        .instr_ready(instr_ready), .mem_req(mem_req), .mem_ack(mem_ack),
        .branch(branch), .ext_sel(ext_sel), .rb_sel(rb_sel), .opb_sel(opb_sel),
        .alu_func(alu_func), .wd_sel(wd_sel), .wr_en(wr_en), .wm_en(wm_en),
        .flag_en(flag_en), .pc_en(pc_en), .busy(busy), .err(err)
`ifdef CU_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    assign st   = {busy, pc_en, wr_en, mem_req, wm_en, flag_en, err, instr_ready};
    assign ctrl = {branch, ext_sel, opb_sel, alu_func, wd_sel, rb_sel};

    // decode table, {branch, ext_sel, opb_sel, alu_func, wd_sel, rb_sel}
    function automatic logic [7:0] exp_ctrl(input logic [2:0] op, input logic [1:0] fn);
        casez ({op, fn})
            5'b000_00, 5'b001_10: return 8'b11_11_0_0_0_0 | {4'b0, 1'b0, fn[1], 2'b0};
            5'b000_01: return 8'b11_00_1_0_0_0;
            5'b000_10: return 8'b11_11_0_1_0_0;
            5'b000_11, 5'b001_11: return 8'b11_00_1_1_0_0;
            5'b010_??: return 8'b11_01_1_0_1_0;
            5'b011_??: return 8'b11_01_1_0_0_1;
            5'b100_??: return 8'b00_10_0_0_0_0;
            5'b101_??: return 8'b01_10_0_0_0_0;
            5'b110_??: return 8'b10_10_0_0_0_0;
            default:   return 8'b11_10_0_0_0_0;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input int k);
        return op == 3'b000 ? 4 : op == 3'b010 ? 4 + k : op == 3'b011 ? 3 + k : 3;
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        instr_valid = 1'b0;
        mem_ack = 1'b0;
        opcode = '0;
        funct = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic offer(input logic [2:0] op, input logic [1:0] fn);
        opcode = op;
        funct = fn;
        instr_valid = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        tests_run++;
        if (st !== 8'b0000_0001) begin
            fails++;
            $display("FAIL reset_status got %b want 00000001", st);
        end
        tests_run++;
        if (ctrl !== 8'b11_00_0000) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 11000000", ctrl);
        end
    endtask

    task automatic test_add;
        offer(3'b000, 2'b00);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                instr_valid = 1'b0;
                opcode = 3'($urandom);
                funct = 2'($urandom);
            end
            tests_run++;
            if ({wr_en, pc_en} !== {c == 3, c == 4}) begin
                fails++;
                $display("FAIL add_strobes c=%0d got wr/pc %b%b want %b%b", c, wr_en, pc_en, c == 3, c == 4);
            end
            if (c == 3) begin
                tests_run++;
                if ({ext_sel, opb_sel, alu_func} !== 4'b11_0_0) begin
                    fails++;
                    $display("FAIL add_ctrl got %b want 1100", {ext_sel, opb_sel, alu_func});
                end
            end
        end
    endtask

    task automatic test_str;
        int n_req = 0, n_wm = 0, n_wr = 0;
        offer(3'b011, 2'($urandom));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) instr_valid = 1'b0;
            n_req += int'(mem_req);
            n_wm += int'(wm_en);
            n_wr += int'(wr_en);
            if (c == 3) begin
                tests_run++;
                if (rb_sel !== 1'b1) begin
                    fails++;
                    $display("FAIL str_rb_sel got %b want 1", rb_sel);
                end
            end
            mem_ack = c == 4;
        end
        tests_run++;
        if ({n_req, n_wm, n_wr} !== {32'd2, 32'd2, 32'd0}) begin
            fails++;
            $display("FAIL str_counts got req=%0d wm=%0d wr=%0d want 2 2 0", n_req, n_wm, n_wr);
        end
        tests_run++;
        if (pc_en !== 1'b1) begin
            fails++;
            $display("FAIL str_pc_en got %b want 1", pc_en);
        end
    endtask

    task automatic test_ldr_timeout;
        offer(3'b010, 2'b00);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            tests_run++;
            if ({err, mem_req, instr_ready, wr_en, wm_en, flag_en, pc_en} !== {c >= 7, c >= 3 && c <= 6, 5'b0}) begin
                fails++;
                $display("FAIL ldr_timeout c=%0d got %b want %b", c,
                         {err, mem_req, instr_ready, wr_en, wm_en, flag_en, pc_en}, {c >= 7, c >= 3 && c <= 6, 5'b0});
            end
        end
        do_reset();
        tests_run++;
        if (st !== 8'b0000_0001) begin
            fails++;
            $display("FAIL err_reset got %b want 00000001", st);
        end
    endtask

    task automatic test_illegal;
        offer(3'b001, 2'($urandom_range(0, 1)));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) instr_valid = 1'b0;
            tests_run++;
            if (st !== {1'b1, 5'b0, c >= 2, 1'b0}) begin
                fails++;
                $display("FAIL illegal c=%0d got %b want %b", c, st, {1'b1, 5'b0, c >= 2, 1'b0});
            end
        end
        do_reset();
    endtask

    task automatic test_rst_mid_mem;
        offer(3'b010, 2'b00);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) instr_valid = 1'b0;
        end
        tests_run++;
        if (mem_req !== 1'b1) begin
            fails++;
            $display("FAIL mid_mem_req got %b want 1", mem_req);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({st, ctrl} !== {8'b0000_0001, 8'b11_00_0000}) begin
            fails++;
            $display("FAIL rst_mid_mem got %b want 0000000111000000", {st, ctrl});
        end
    endtask

    task automatic test_random(input int n);
        logic [2:0] op;
        logic [1:0] fn;
        logic [7:0] want;
        int k, lat;
        for (int i = 0; i < n; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                instr_valid = 1'b0;
                @(negedge clk);
                tests_run++;
                if (st !== 8'b0000_0001) begin
                    fails++;
                    $display("FAIL idle got %b want 00000001", st);
                end
            end
            do begin
                op = 3'($urandom);
                fn = 2'($urandom);
            end while (op == 3'b001 && !fn[1]);
            k = $urandom_range(1, 3);
            lat = latency(op, k);
            offer(op, fn);
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    instr_valid = 1'b0;
                    opcode = 3'($urandom);
                    funct = 2'($urandom);
                end
                want[7] = c < lat;
                want[6] = c == lat;
                want[5] = (op == 3'b000 && c == 3) || (op == 3'b010 && c == 3 + k);
                want[4] = (op == 3'b010 || op == 3'b011) && c >= 3 && c <= 2 + k;
                want[3] = op == 3'b011 && want[4];
                want[2] = op == 3'b001 && c == 2;
                want[1] = 1'b0;
                want[0] = c == lat;
                tests_run++;
                if (st !== want) begin
                    fails++;
                    $display("FAIL rand_status op=%0d fn=%0d k=%0d c=%0d got %b want %b", op, fn, k, c, st, want);
                end
                if (c >= 2 && c < lat) begin
                    tests_run++;
                    if (ctrl !== exp_ctrl(op, fn)) begin
                        fails++;
                        $display("FAIL rand_ctrl op=%0d fn=%0d c=%0d got %b want %b", op, fn, c, ctrl, exp_ctrl(op, fn));
                    end
                end
                mem_ack = (op == 3'b010 || op == 3'b011) && c == 2 + k;
            end
        end
        instr_valid = 1'b0;
    endtask

`ifdef CU_RETIRE_CNT_EN
    task automatic test_retired;
        do_reset();
        tests_run++;
        if (retired !== 2'd0) begin
            fails++;
            $display("FAIL retired_reset got %0d want 0", retired);
        end
        for (int i = 0; i < 5; i++) begin
            offer(3'b111, 2'($urandom));
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                if (c == 1) instr_valid = 1'b0;
            end
        end
        @(negedge clk);
        tests_run++;
        if (retired !== 2'd1) begin
            fails++;
            $display("FAIL retired_wrap got %0d want 1", retired);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_str();
        test_ldr_timeout();
        test_illegal();
        test_rst_mid_mem();
        test_random(60);
`ifdef CU_RETIRE_CNT_EN
        test_retired();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
